// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared types, scan-code constants and helpers for ps2_key_tracker
// Contents: decoder state enum, Set-2 scan-code constants, event struct,
//           modifier-side and discard-byte classification functions.
package kb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_state_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // Pause sends 7 further bytes after its leading E1.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef struct packed {
    logic [8:0] key;
    logic       brk;
    logic       rpt;
    logic [2:0] mods;
  } kb_evt_t;

  // One bit per modifier side: {ralt, lalt, rctrl, lctrl, rshift, lshift}.
  function automatic logic [5:0] mod_mask(input logic [8:0] id);
    case (id)
      {1'b0, SC_LSHIFT}: mod_mask = 6'b000001;
      {1'b0, SC_RSHIFT}: mod_mask = 6'b000010;
      {1'b0, SC_CTRL}:   mod_mask = 6'b000100;
      {1'b1, SC_CTRL}:   mod_mask = 6'b001000;
      {1'b0, SC_ALT}:    mod_mask = 6'b010000;
      {1'b1, SC_ALT}:    mod_mask = 6'b100000;
      default:           mod_mask = 6'b000000;
    endcase
  endfunction

  // Keyboard housekeeping bytes that are thrown away in any decoder state.
  function automatic logic is_discard(input logic [7:0] b);
    is_discard = (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// rtl/kb_event_fifo.sv - first-word-fall-through FIFO of key events
// Ports: clk, clrn (sync active-low reset), push/push_data (write),
//        pop (advance head), head (current oldest entry), full, empty.
// A push while full is ignored unless a pop happens in the same cycle.
module kb_event_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    clrn,
  input  logic    push,
  input  kb_evt_t push_data,
  input  logic    pop,
  output kb_evt_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  kb_evt_t       mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 Set-2 make/break decoder, held-key table and event FIFO
// Ports: clk, clrn (sync active-low reset); ready/data/nextdata_n byte handshake
//        with ps2_keyboard; evt_valid/evt_ready/evt_key/evt_break/evt_repeat/evt_mods
//        event stream; mods, key_down, held_cnt status; rollover, evt_drop pulses.
// Build option: KB_REPEAT_EN - emit repeated makes of a held key as evt_repeat=1 events.
module ps2_key_tracker
  import kb_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ready,
  input  logic [7:0] data,
  output logic       nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [8:0] evt_key,
  output logic       evt_break,
  output logic       evt_repeat,
  output logic [2:0] evt_mods,
  output logic [2:0] mods,
  output logic       key_down,
  output logic [3:0] held_cnt,
  output logic       rollover,
  output logic       evt_drop
);

`ifdef KB_REPEAT_EN
  localparam logic RPT_EN = 1'b1;
`else
  localparam logic RPT_EN = 1'b0;
`endif

  localparam int IW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  dec_state_t  state, state_nx;
  logic [2:0]  skip_cnt, skip_nx;
  logic        ack_pend;
  logic        accept;
  logic [N_KEYS-1:0] slot_vld, vld_nx;
  logic [8:0]  slot_key [N_KEYS];
  logic [8:0]  key_nx   [N_KEYS];
  logic [5:0]  side, side_nx;
  logic        roll_q, roll_nx;
  logic        drop_q;

  logic        make_ev, brk_ev, err_ev;
  logic [8:0]  cur_id;
  logic [5:0]  cur_mask;
  logic        hit, free_ok;
  logic [IW-1:0] hit_idx, free_idx;
  logic [3:0]  cnt;

  logic        push;
  kb_evt_t     push_evt;
  kb_evt_t     head;
  logic        fifo_full, fifo_empty;

  // One byte per ack: a byte that stays on data while the ack pulse is out
  // is not consumed twice.
  assign accept   = ready & ~ack_pend;
  assign cur_id   = {(state == ST_EXT) || (state == ST_EXT_BRK), data};
  assign cur_mask = mod_mask(cur_id);

  // Decoder next state and event classification.
  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    make_ev  = 1'b0;
    brk_ev   = 1'b0;
    err_ev   = 1'b0;
    if (accept) begin
      if (data == SC_ERR0 || data == SC_ERR1) begin
        err_ev   = 1'b1;
        state_nx = ST_IDLE;
      end else if (is_discard(data)) begin
        state_nx = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (data == SC_E0) state_nx = ST_EXT;
            else if (data == SC_F0) state_nx = ST_BRK;
            else if (data == SC_E1) begin
              state_nx = ST_SKIP;
              skip_nx  = PAUSE_TAIL;
            end else make_ev = 1'b1;
          end
          ST_EXT: begin
            if (data == SC_F0) state_nx = ST_EXT_BRK;
            else begin
              state_nx = ST_IDLE;
              make_ev  = (data != SC_LSHIFT);  // E0-12 is a fake shift
            end
          end
          ST_BRK: begin
            state_nx = ST_IDLE;
            brk_ev   = 1'b1;
          end
          ST_EXT_BRK: begin
            state_nx = ST_IDLE;
            brk_ev   = (data != SC_LSHIFT);    // E0-F0-12 is a fake shift
          end
          ST_SKIP: begin
            if (skip_cnt == 3'd1 || skip_cnt == 3'd0) begin
              state_nx = ST_IDLE;
              skip_nx  = 3'd0;
            end else begin
              skip_nx = skip_cnt - 3'd1;
            end
          end
          default: state_nx = ST_IDLE;
        endcase
      end
    end
  end

  // Table search: existing slot holding this id, and lowest free slot.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (slot_vld[i] && slot_key[i] == cur_id) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!slot_vld[i]) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Table, modifier and event generation.
  always_comb begin
    vld_nx        = slot_vld;
    key_nx        = slot_key;
    side_nx       = side;
    roll_nx       = 1'b0;
    push          = 1'b0;
    push_evt.key  = cur_id;
    push_evt.brk  = brk_ev;
    push_evt.rpt  = 1'b0;
    push_evt.mods = mods;
    if (err_ev) begin
      vld_nx  = '0;
      side_nx = '0;
    end else if (make_ev || brk_ev) begin
      if (cur_mask != '0) begin
        side_nx = make_ev ? (side | cur_mask) : (side & ~cur_mask);
      end else if (make_ev) begin
        if (hit) begin
          push         = RPT_EN;
          push_evt.rpt = 1'b1;
        end else if (free_ok) begin
          vld_nx[free_idx] = 1'b1;
          key_nx[free_idx] = cur_id;
          push             = 1'b1;
        end else begin
          roll_nx = 1'b1;
        end
      end else if (hit) begin
        vld_nx[hit_idx] = 1'b0;
        push            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      ack_pend <= 1'b0;
      slot_vld <= '0;
      for (int i = 0; i < N_KEYS; i++) slot_key[i] <= '0;
      side     <= '0;
      roll_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
      ack_pend <= accept;
      slot_vld <= vld_nx;
      slot_key <= key_nx;
      side     <= side_nx;
      roll_q   <= roll_nx;
      drop_q   <= push & fifo_full & ~evt_ready;
    end
  end

  kb_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_KEYS; i++) cnt = cnt + 4'(slot_vld[i]);
  end

  // Head fields are masked while empty so the stream idles at zero.
  assign evt_valid  = ~fifo_empty;
  assign evt_key    = evt_valid ? head.key  : '0;
  assign evt_break  = evt_valid & head.brk;
  assign evt_repeat = evt_valid & head.rpt & RPT_EN;
  assign evt_mods   = evt_valid ? head.mods : '0;
  assign nextdata_n = ~ack_pend;
  assign mods       = {side[5] | side[4], side[3] | side[2], side[1] | side[0]};
  assign key_down   = |slot_vld;
  assign held_cnt   = cnt;
  assign rollover   = roll_q;
  assign evt_drop   = drop_q;

endmodule
